// File: rtl/random_present_gen_if.sv
// Result channel of the present spawner: type and X position under valid/ready.
interface random_present_gen_if #(
   parameter int TYPE_BITS = 2,
   parameter int POS_BITS  = 10
);
   logic                 out_valid;
   logic                 out_ready;
   logic [TYPE_BITS-1:0] present_type;
   logic [POS_BITS-1:0]  present_x;

   modport master (output out_valid, present_type, present_x, input out_ready);
   modport slave  (input out_valid, present_type, present_x, output out_ready);
endinterface

// File: rtl/random_present_gen.sv
// Random present spawner: LFSR-driven type/X draw with rejection sampling,
// optional no-repeat on type, result held under valid/ready.
module random_present_gen #(
   parameter int          N_TYPES   = 4,
   parameter int          TYPE_BITS = 2,
   parameter int          POS_BITS  = 10,
   parameter int          POS_MIN   = 0,
   parameter int          POS_MAX   = 479,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          NO_REPEAT = 1,
   parameter int          MAX_TRIES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rise,
   input  logic                  seed_load,
   input  logic [15:0]           seed_val,
   output logic                  missed,
   random_present_gen_if.master  spawn
);
   localparam int                 TRY_W   = $clog2(MAX_TRIES + 1);
   localparam logic [TRY_W-1:0]   TRY_LIM = TRY_W'(MAX_TRIES);
   localparam logic [TRY_W-1:0]   TRY_ONE = TRY_W'(1);
   localparam logic [TYPE_BITS:0] N_T     = (TYPE_BITS+1)'(N_TYPES);
   localparam logic [TYPE_BITS:0] T_ONE   = (TYPE_BITS+1)'(1);
   localparam logic [POS_BITS:0]  P_MIN   = (POS_BITS+1)'(POS_MIN);
   localparam logic [POS_BITS:0]  P_SPAN  = (POS_BITS+1)'(POS_MAX - POS_MIN);
   localparam logic [15:0]        SEED0   = (LFSR_SEED == 16'h0) ? 16'h1 : LFSR_SEED;
   localparam bit                 REP_CHK = (NO_REPEAT != 0) && (N_TYPES > 1);
   localparam bit                 REP_FB  = (NO_REPEAT != 0);

   typedef enum logic [1:0] {IDLE, DRAW_TYPE, DRAW_POS, VALID} state_e;

   state_e               state_q, state_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic                 rise_dly_q;
   logic                 missed_q;
   logic [TRY_W-1:0]     try_q, try_d;
   logic [TYPE_BITS-1:0] type_q, type_d;
   logic [TYPE_BITS-1:0] last_q, last_d;
   logic                 have_last_q, have_last_d;
   logic [POS_BITS-1:0]  x_q, x_d;

   logic                 trig;
   logic [TYPE_BITS-1:0] t_cand, t_fb;
   logic [TYPE_BITS:0]   t_nxt;
   logic                 t_rej;
   logic [POS_BITS:0]    p_off, p_sum;
   logic                 p_rej;

   assign trig = rise && !rise_dly_q;

   // Galois right shift; a zero seed would lock the register, so it becomes 1.
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      if (seed_load) lfsr_d = (seed_val == 16'h0) ? 16'h1 : seed_val;
   end

   always_comb begin
      t_cand = lfsr_q[TYPE_BITS-1:0];
      t_rej  = ({1'b0, t_cand} >= N_T) || (REP_CHK && have_last_q && (t_cand == last_q));
      t_nxt  = {1'b0, last_q} + T_ONE;
      t_fb   = '0;
      if (REP_FB && have_last_q && (t_nxt < N_T)) t_fb = t_nxt[TYPE_BITS-1:0];
      p_off  = {1'b0, lfsr_q[15 -: POS_BITS]};
      p_rej  = p_off > P_SPAN;
      p_sum  = P_MIN + p_off;
   end

   always_comb begin
      state_d     = state_q;
      try_d       = try_q;
      type_d      = type_q;
      x_d         = x_q;
      last_d      = last_q;
      have_last_d = have_last_q;
      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d = DRAW_TYPE;
               try_d   = '0;
            end
         end
         DRAW_TYPE: begin
            if (try_q == TRY_LIM) begin
               type_d  = t_fb;
               try_d   = '0;
               state_d = DRAW_POS;
            end else if (!t_rej) begin
               type_d  = t_cand;
               try_d   = '0;
               state_d = DRAW_POS;
            end else begin
               try_d = try_q + TRY_ONE;
            end
         end
         DRAW_POS: begin
            if (try_q == TRY_LIM) begin
               x_d     = P_MIN[POS_BITS-1:0];
               try_d   = '0;
               state_d = VALID;
            end else if (!p_rej) begin
               x_d     = p_sum[POS_BITS-1:0];
               try_d   = '0;
               state_d = VALID;
            end else begin
               try_d = try_q + TRY_ONE;
            end
         end
         VALID: begin
            if (spawn.out_ready) begin
               last_d      = type_q;
               have_last_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         lfsr_q      <= SEED0;
         rise_dly_q  <= 1'b0;
         missed_q    <= 1'b0;
         try_q       <= '0;
         type_q      <= '0;
         last_q      <= '0;
         have_last_q <= 1'b0;
         x_q         <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         rise_dly_q  <= rise;
         missed_q    <= trig && (state_q != IDLE);
         try_q       <= try_d;
         type_q      <= type_d;
         last_q      <= last_d;
         have_last_q <= have_last_d;
         x_q         <= x_d;
      end
   end

   assign spawn.out_valid    = (state_q == VALID);
   assign spawn.present_type = type_q;
   assign spawn.present_x    = x_q;
   assign missed             = missed_q;
endmodule

// File: tb/tb_random_present_gen.sv
// Directed bench: default instance against an LFSR/draw model, plus degenerate
// bounds and three-type no-repeat instances checked for their properties.
module tb_random_present_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic        a_rst = 1'b1, a_rise = 1'b0, a_sl = 1'b0, a_miss;
   logic [15:0] a_sv  = 16'h0;
   logic        b_rst = 1'b1, b_rise = 1'b0, b_miss;
   logic        c_rst = 1'b1, c_rise = 1'b0, c_miss;

   random_present_gen_if #(.TYPE_BITS(2), .POS_BITS(10)) a_if();
   random_present_gen_if #(.TYPE_BITS(1), .POS_BITS(10)) b_if();
   random_present_gen_if #(.TYPE_BITS(2), .POS_BITS(10)) c_if();

   random_present_gen u_a (
      .clk(clk), .reset(a_rst), .rise(a_rise), .seed_load(a_sl), .seed_val(a_sv),
      .missed(a_miss), .spawn(a_if)
   );
   random_present_gen #(.N_TYPES(1), .TYPE_BITS(1), .POS_MIN(100), .POS_MAX(100)) u_b (
      .clk(clk), .reset(b_rst), .rise(b_rise), .seed_load(1'b0), .seed_val(16'h0),
      .missed(b_miss), .spawn(b_if)
   );
   random_present_gen #(.N_TYPES(3), .TYPE_BITS(2)) u_c (
      .clk(clk), .reset(c_rst), .rise(c_rise), .seed_load(1'b0), .seed_val(16'h0),
      .missed(c_miss), .spawn(c_if)
   );

   logic [15:0] m_lfsr = 16'hACE1;
   int          m_last = 0;
   bit          m_have = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] step(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   // Inputs are stable across the edge, so the model reads the same values the DUT samples.
   task automatic tick;
      @(posedge clk);
      if (a_rst)     m_lfsr = 16'hACE1;
      else if (a_sl) m_lfsr = (a_sv == 16'h0) ? 16'h1 : a_sv;
      else           m_lfsr = step(m_lfsr);
      #1;
   endtask

   // Draw model for the default instance; l0 is the LFSR in the trigger cycle.
   task automatic predict(input logic [15:0] l0, output int lat, output int tp,
                          output int ty, output int x);
      logic [15:0] l;
      int c, tr, o;
      l = step(l0); c = 1; tr = 0;
      while (1) begin
         if (tr == 8) begin ty = m_have ? (m_last + 1) % 4 : 0; break; end
         if (!(m_have && int'(l[1:0]) == m_last)) begin ty = int'(l[1:0]); break; end
         tr++; c++; l = step(l);
      end
      c++; l = step(l); tr = 0; tp = c;
      while (1) begin
         if (tr == 8) begin x = 0; break; end
         o = int'(l[15:6]);
         if (o <= 479) begin x = o; break; end
         tr++; c++; l = step(l);
      end
      lat = c + 1;
   endtask

   task automatic spawn_a(input string tag, output int ty, output int x);
      int lat, tp, n;
      predict(m_lfsr, lat, tp, ty, x);
      a_rise = 1'b1; tick; a_rise = 1'b0; n = 1;
      while (!a_if.out_valid && n < 40) begin tick; n++; end
      chk({tag, ".lat"}, n, lat);
      chk({tag, ".latmax"}, n <= 19, 1);
      chk({tag, ".type"}, a_if.present_type, ty);
      chk({tag, ".x"}, a_if.present_x, x);
      chk({tag, ".xrng"}, a_if.present_x <= 10'd479, 1);
   endtask

   initial begin
      int ty, x, lat, tp, n, nm, prev;
      int cnt[3];
      a_if.out_ready = 1'b1;
      b_if.out_ready = 1'b1;
      c_if.out_ready = 1'b1;

      // reset and idle, with the LFSR sequence from ACE1
      tick; tick;
      chk("rst.valid", a_if.out_valid, 0);
      chk("rst.type", a_if.present_type, 0);
      chk("rst.x", a_if.present_x, 0);
      chk("rst.miss", a_miss, 0);
      chk("rst.lfsr", u_a.lfsr_q, 16'hACE1);
      a_rst = 1'b0;
      chk("lfsr0", u_a.lfsr_q, 16'hACE1);
      tick; chk("lfsr1", u_a.lfsr_q, 16'hE270);
      tick; chk("lfsr2", u_a.lfsr_q, 16'h7138);
      tick; chk("lfsr3", u_a.lfsr_q, 16'h389C);
      for (int i = 0; i < 17; i++) begin
         tick;
         chk("idle.lfsr", u_a.lfsr_q, m_lfsr);
         chk("idle.valid", a_if.out_valid, 0);
         chk("idle.miss", a_miss, 0);
      end

      // back-to-back spawns with the consumer always ready
      for (int i = 0; i < 8; i++) begin
         spawn_a("spawn", ty, x);
         tick;
         chk("spawn.vlow", a_if.out_valid, 0);
         m_last = ty; m_have = 1'b1;
         tick;
      end

      // backpressure: three dropped edges while held, then a same-cycle edge at handshake
      a_if.out_ready = 1'b0;
      spawn_a("bp", ty, x);
      nm = 0;
      for (int i = 0; i < 10; i++) begin
         a_rise = (i == 1 || i == 4 || i == 7);
         tick;
         chk("bp.valid", a_if.out_valid, 1);
         chk("bp.type", a_if.present_type, ty);
         chk("bp.x", a_if.present_x, x);
         chk("bp.miss", a_miss, (i == 1 || i == 4 || i == 7));
         if (a_miss) nm++;
      end
      chk("bp.nmiss", nm, 3);
      a_if.out_ready = 1'b1;
      a_rise = 1'b1;
      tick;
      chk("bp.done", a_if.out_valid, 0);
      chk("bp.hsmiss", a_miss, 1);
      m_last = ty; m_have = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk("held.valid", a_if.out_valid, 0);
         chk("held.miss", a_miss, 0);
      end
      a_rise = 1'b0;
      tick;

      // zero seed loads as 1, then shifts to B400
      a_sl = 1'b1; a_sv = 16'h0;
      tick; a_sl = 1'b0;
      chk("seed.one", u_a.lfsr_q, 16'h0001);
      tick; chk("seed.b400", u_a.lfsr_q, 16'hB400);
      tick; chk("seed.5a00", u_a.lfsr_q, 16'h5A00);
      spawn_a("seeded", ty, x);
      tick; m_last = ty; m_have = 1'b1;
      tick;

      // reset in the first DRAW_POS cycle loses the draw
      predict(m_lfsr, lat, tp, ty, x);
      a_rise = 1'b1; tick; a_rise = 1'b0;
      for (int i = 1; i < tp; i++) tick;
      chk("mid.inpos", u_a.state_q == u_a.DRAW_POS, 1);
      a_rst = 1'b1; tick; a_rst = 1'b0;
      m_have = 1'b0; m_last = 0;
      chk("mid.valid", a_if.out_valid, 0);
      chk("mid.lfsr", u_a.lfsr_q, 16'hACE1);
      for (int i = 0; i < 25; i++) begin
         tick;
         chk("mid.none", a_if.out_valid, 0);
      end
      spawn_a("post", ty, x);
      tick;

      // degenerate bounds: single type, single position
      b_rst = 1'b0; tick;
      for (int i = 0; i < 200; i++) begin
         b_rise = 1'b1; tick; b_rise = 1'b0; n = 1;
         while (!b_if.out_valid && n < 40) begin tick; n++; end
         chk("deg.valid", b_if.out_valid, 1);
         chk("deg.latmax", n <= 19, 1);
         chk("deg.x", b_if.present_x, 100);
         chk("deg.type", b_if.present_type, 0);
         tick;
      end
      chk("deg.miss", b_miss, 0);

      // three types with no-repeat
      c_rst = 1'b0; tick;
      cnt = '{0, 0, 0};
      prev = -1;
      for (int i = 0; i < 1000; i++) begin
         c_rise = 1'b1; tick; c_rise = 1'b0; n = 1;
         while (!c_if.out_valid && n < 40) begin tick; n++; end
         chk("nr.valid", c_if.out_valid, 1);
         chk("nr.lt3", c_if.present_type < 2'd3, 1);
         if (prev >= 0) chk("nr.rep", int'(c_if.present_type) != prev, 1);
         prev = int'(c_if.present_type);
         if (prev < 3) cnt[prev]++;
         tick;
      end
      chk("nr.cnt0", cnt[0] >= 250, 1);
      chk("nr.cnt1", cnt[1] >= 250, 1);
      chk("nr.cnt2", cnt[2] >= 250, 1);
      chk("nr.miss", c_miss, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
